// File: rtl/core_lsu_pkg.sv
// Shared constants, FSM state type and store-side lane helpers for core_lsu.
package core_lsu_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} lsu_state_t;

    // size = funct3[1:0]: 0 byte, 1 half, else word
    function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lsu_be = 4'b0001 << off;
            2'b01:   lsu_be = 4'b0011 << {off[1], 1'b0};
            default: lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lsu_wdata = {4{wd[7:0]}};
            2'b01:   lsu_wdata = {2{wd[15:0]}};
            default: lsu_wdata = wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and sign/zero-extends the addressed byte/half of a load word.
module lsu_load_align
    import core_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      data = {{(XLEN-8){b[7]}}, b};
            LBU:     data = {{(XLEN-8){1'b0}}, b};
            LH:      data = {{(XLEN-16){h[15]}}, h};
            LHU:     data = {{(XLEN-16){1'b0}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one data-bus transaction at a time with pipeline hold and watchdog.
// Optional CORE_LSU_MISALIGN_EXC_EN: misaligned accesses raise o_misaligned instead of issuing.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_ready,
    output logic            o_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
`ifdef CORE_LSU_MISALIGN_EXC_EN
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_misaligned_addr,
`endif
    output logic            o_bus_err
);

    lsu_state_t      state, state_n;
    logic            is_load, is_store, legal, accept, timeout;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [1:0]      off_q;
    logic [31:0]     wd_cnt;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        is_load  = (i_opcode == LOAD) &&
                   (i_funct3 inside {LB, LH, LW, LBU, LHU});
        is_store = (i_opcode == STORE) && (i_funct3 inside {SB, SH, SW});
        legal    = i_valid && (is_load || is_store);
    end

`ifdef CORE_LSU_MISALIGN_EXC_EN
    logic mis;
    assign mis    = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                    ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign accept = legal && !mis;
`else
    assign accept = legal;
`endif

    // Counter value TIMEOUT_CYCLES-1 marks the last cycle allowed in REQ/WAIT_R
    assign timeout = (TIMEOUT_CYCLES != 0) && (wd_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = REQ;
            REQ:     if (i_dmem_gnt) state_n = o_dmem_we ? IDLE : WAIT_R;
                     else if (timeout) state_n = IDLE;
            WAIT_R:  if (i_dmem_rvalid || timeout) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state == IDLE);
        o_stall    = (state != IDLE);
        o_dmem_req = (state == REQ);
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (i_dmem_rdata),
        .funct3 (f3_q),
        .off    (off_q),
        .data   (ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_dmem_we    <= 1'b0;
            o_dmem_be    <= '0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            off_q        <= '0;
            wd_cnt       <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_rd      <= '0;
            o_wb_data    <= '0;
            o_bus_err    <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            o_bus_err  <= 1'b0;
            if (state == IDLE && accept) begin
                o_dmem_we    <= is_store;
                o_dmem_be    <= lsu_be(i_funct3[1:0], i_addr[1:0]);
                o_dmem_addr  <= {i_addr[XLEN-1:2], 2'b00};
                o_dmem_wdata <= lsu_wdata(i_funct3[1:0], i_wdata);
                f3_q         <= i_funct3;
                rd_q         <= i_rd;
                off_q        <= i_addr[1:0];
            end
            if (state == WAIT_R && i_dmem_rvalid) begin
                o_wb_valid <= (rd_q != 5'd0);
                o_wb_rd    <= rd_q;
                o_wb_data  <= ld_data;
            end
            if (timeout && ((state == REQ && !i_dmem_gnt) ||
                            (state == WAIT_R && !i_dmem_rvalid)))
                o_bus_err <= 1'b1;
            if (state == IDLE || state_n != state) wd_cnt <= '0;
            else                                   wd_cnt <= wd_cnt + 32'd1;
        end
    end

`ifdef CORE_LSU_MISALIGN_EXC_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_misaligned      <= 1'b0;
            o_misaligned_addr <= '0;
        end else begin
            o_misaligned <= (state == IDLE) && legal && mis;
            if (state == IDLE && legal && mis) o_misaligned_addr <= i_addr;
        end
    end
`endif

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: loads push expected writebacks, a monitor pops them.
module tb_core_lsu;
    import core_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, valid, gnt, rvalid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] addr, wdata, rdata;
    logic        ready, stall, req, we, wb_valid, bus_err;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata, wb_data;
    logic [4:0]  wb_rd;
`ifdef CORE_LSU_MISALIGN_EXC_EN
    logic        misaligned;
    logic [31:0] misaligned_addr;
`endif

    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    wb_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    core_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_opcode(opcode),
        .i_funct3(funct3), .i_rd(rd), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready), .o_stall(stall), .o_dmem_req(req), .o_dmem_we(we),
        .o_dmem_be(be), .o_dmem_addr(maddr), .o_dmem_wdata(mwdata),
        .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
`ifdef CORE_LSU_MISALIGN_EXC_EN
        .o_misaligned(misaligned), .o_misaligned_addr(misaligned_addr),
`endif
        .o_bus_err(bus_err)
    );

    // Writeback monitor: every strobe must match the oldest pending load
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    failures++;
                    $display("FAIL wb_data got rd=%0d data=%h, expected rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] wd);
        valid = 1'b1; opcode = op; funct3 = f3; rd = r; addr = a; wdata = wd;
        step();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 0; opcode = 0; funct3 = 0; rd = 0; addr = 0; wdata = 0;
        gnt = 0; rvalid = 0; rdata = 0;
        step(); step();
        rst_n = 1'b1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b expected 1", ready); end
        checks++; if ({stall, req, we, wb_valid, bus_err} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got %b expected 00000", {stall, req, we, wb_valid, bus_err}); end
        checks++; if ({be, maddr, mwdata, wb_data} !== '0) begin failures++; $display("FAIL reset_data got be=%h addr=%h wd=%h wb=%h expected 0", be, maddr, mwdata, wb_data); end
    endtask

    task automatic test_store_sb();
        issue(STORE, SB, 5'd0, 32'h1003, 32'h0000_00AB);
        checks++; if ({req, we} !== 2'b11) begin failures++; $display("FAIL sb_req got req/we=%b expected 11", {req, we}); end
        checks++; if (be !== 4'b1000) begin failures++; $display("FAIL sb_be got %b expected 1000", be); end
        checks++; if (maddr !== 32'h1000) begin failures++; $display("FAIL sb_addr got %h expected 00001000", maddr); end
        checks++; if (mwdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got %h expected ababab ab", mwdata); end
        gnt = 1'b1; step(); gnt = 1'b0;
        checks++; if ({ready, req} !== 2'b10) begin failures++; $display("FAIL sb_done got ready/req=%b expected 10", {ready, req}); end
    endtask

    task automatic test_load_byte();
        logic [2:0]  f3s [2];
        logic [31:0] exps[2];
        f3s[0] = LB;  exps[0] = 32'hFFFF_FF80;
        f3s[1] = LBU; exps[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            issue(LOAD, f3s[i], 5'd5, 32'h2001, 32'h0);
            exp_q.push_back('{5'd5, exps[i]});
            checks++; if ({req, we, be} !== 6'b10_0010 || maddr !== 32'h2000) begin failures++; $display("FAIL lb_req got req/we/be=%b addr=%h expected 100010 00002000", {req, we, be}, maddr); end
            gnt = 1'b1; step(); gnt = 1'b0;
            checks++; if ({req, stall} !== 2'b01) begin failures++; $display("FAIL lb_waitr got req/stall=%b expected 01", {req, stall}); end
            rvalid = 1'b1; rdata = 32'h0000_8000; step(); rvalid = 1'b0;
            checks++; if ({wb_valid, ready} !== 2'b11) begin failures++; $display("FAIL lb_wb got wb/ready=%b expected 11", {wb_valid, ready}); end
            step();
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL lb_pulse got %b expected 0", wb_valid); end
        end
    endtask

    task automatic test_lw_delayed();
        issue(LOAD, LW, 5'd7, 32'h4000, 32'h0);
        exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
        rvalid = 1'b1; rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({req, stall, ready} !== 3'b110 || maddr !== 32'h4000 || be !== 4'hF) begin failures++; $display("FAIL lw_hold cycle %0d got req/stall/ready=%b addr=%h be=%h", i, {req, stall, ready}, maddr, be); end
            step();
            rvalid = 1'b0;
        end
        gnt = 1'b1;
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL lw_req_at_gnt got %b expected 1", req); end
        step(); gnt = 1'b0;
        checks++; if ({req, stall, ready} !== 3'b010) begin failures++; $display("FAIL lw_waitr got req/stall/ready=%b expected 010", {req, stall, ready}); end
        step();
        checks++; if ({stall, wb_valid} !== 2'b10) begin failures++; $display("FAIL lw_wait2 got stall/wb=%b expected 10", {stall, wb_valid}); end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; step(); rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL lw_wb got %b expected 1", wb_valid); end
        step();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL lw_pulse got %b expected 0", wb_valid); end
    endtask

    task automatic test_rd_zero_and_ignore();
        issue(LOAD, LW, 5'd0, 32'h4100, 32'h0);
        gnt = 1'b1; step(); gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555_AAAA; step(); rvalid = 1'b0;
        checks++; if ({wb_valid, ready} !== 2'b01) begin failures++; $display("FAIL rd0 got wb/ready=%b expected 01", {wb_valid, ready}); end
        issue(7'b0110011, 3'd0, 5'd1, 32'h10, 32'h0);
        checks++; if ({req, ready} !== 2'b01) begin failures++; $display("FAIL ign_opc got req/ready=%b expected 01", {req, ready}); end
        issue(LOAD, 3'd3, 5'd1, 32'h10, 32'h0);
        checks++; if ({req, ready} !== 2'b01) begin failures++; $display("FAIL ign_ld_f3 got req/ready=%b expected 01", {req, ready}); end
        issue(STORE, 3'd4, 5'd1, 32'h10, 32'h0);
        checks++; if ({req, ready} !== 2'b01) begin failures++; $display("FAIL ign_st_f3 got req/ready=%b expected 01", {req, ready}); end
    endtask

    task automatic test_back_to_back();
        issue(LOAD, LH, 5'd10, 32'h6002, 32'h0);
        exp_q.push_back('{5'd10, 32'hFFFF_8001});
        checks++; if (be !== 4'b1100) begin failures++; $display("FAIL lh_be got %b expected 1100", be); end
        gnt = 1'b1; step(); gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h8001_0000; step(); rvalid = 1'b0;
        checks++; if ({wb_valid, ready} !== 2'b11) begin failures++; $display("FAIL b2b_first got wb/ready=%b expected 11", {wb_valid, ready}); end
        issue(LOAD, LHU, 5'd11, 32'h6002, 32'h0);
        exp_q.push_back('{5'd11, 32'h0000_8001});
        checks++; if ({req, wb_valid} !== 2'b10) begin failures++; $display("FAIL b2b_accept got req/wb=%b expected 10", {req, wb_valid}); end
        gnt = 1'b1; step(); gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h8001_0000; step(); rvalid = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        issue(LOAD, LW, 5'd3, 32'h5000, 32'h0);
        gnt = 1'b1; step(); gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({stall, bus_err} !== 2'b10) begin failures++; $display("FAIL to_wait cycle %0d got stall/err=%b expected 10", i, {stall, bus_err}); end
            step();
        end
        checks++; if ({bus_err, ready, wb_valid} !== 3'b110) begin failures++; $display("FAIL to_pulse got err/ready/wb=%b expected 110", {bus_err, ready, wb_valid}); end
        rvalid = 1'b1; rdata = 32'h7777_7777; step(); rvalid = 1'b0;
        checks++; if ({bus_err, ready, wb_valid} !== 3'b010) begin failures++; $display("FAIL to_late got err/ready/wb=%b expected 010", {bus_err, ready, wb_valid}); end
        issue(STORE, SW, 5'd0, 32'h5004, 32'h1234_5678);
        checks++; if ({req, we, be} !== 6'b11_1111 || maddr !== 32'h5004 || mwdata !== 32'h1234_5678) begin failures++; $display("FAIL to_sw got req/we/be=%b addr=%h wd=%h", {req, we, be}, maddr, mwdata); end
        gnt = 1'b1; step(); gnt = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL to_sw_done got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid();
        issue(LOAD, LW, 5'd9, 32'h7000, 32'h0);
        gnt = 1'b1; step(); gnt = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'h9999_9999; step(); rvalid = 1'b0;
        checks++; if ({ready, stall, req, wb_valid, bus_err} !== 5'b10000) begin failures++; $display("FAIL rst_mid_ctrl got %b expected 10000", {ready, stall, req, wb_valid, bus_err}); end
        checks++; if ({be, maddr, mwdata} !== '0) begin failures++; $display("FAIL rst_mid_data got be=%h addr=%h wd=%h expected 0", be, maddr, mwdata); end
    endtask

    task automatic test_misalign();
        issue(LOAD, LW, 5'd4, 32'h3002, 32'h0);
`ifdef CORE_LSU_MISALIGN_EXC_EN
        checks++; if ({misaligned, req, ready} !== 3'b101 || misaligned_addr !== 32'h3002) begin failures++; $display("FAIL mis_exc got mis/req/ready=%b addr=%h expected 101 00003002", {misaligned, req, ready}, misaligned_addr); end
        step();
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_pulse got %b expected 0", misaligned); end
`else
        exp_q.push_back('{5'd4, 32'hCAFE_F00D});
        checks++; if ({req, be} !== 5'b1_1111 || maddr !== 32'h3000) begin failures++; $display("FAIL mis_align got req/be=%b addr=%h expected 11111 00003000", {req, be}, maddr); end
        gnt = 1'b1; step(); gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; step(); rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL mis_wb got %b expected 1", wb_valid); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_store_sb();
        test_load_byte();
        test_lw_delayed();
        test_rd_zero_and_ignore();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_misalign();
        step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wb_missing got %0d pending, expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Load/store unit placed after the EX stage. It consumes the EX outputs (ALU result used as the effective address, forwarded rs2 used as store data, opcode/funct3/rd) and runs a request/grant/response transaction on the data-memory bus. It holds the pipeline while a transaction is in flight. It formats load data and returns it to the register-file writeback path.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; 0 disables the watchdog

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  EX presents an instruction
i_opcode  input  7  instruction opcode
i_funct3  input  3  access size/sign
i_rd  input  5  load destination register
i_addr  input  XLEN  effective address (EX ALU result)
i_wdata  input  XLEN  store data (EX forwarded rs2)
o_ready  output  1  LSU can accept (state IDLE)
o_stall  output  1  pipeline hold
o_dmem_req  output  1  bus request
o_dmem_we  output  1  1 = store
o_dmem_be  output  4  byte enables
o_dmem_addr  output  XLEN  word-aligned address
o_dmem_wdata  output  XLEN  lane-replicated store data
i_dmem_gnt  input  1  request accepted
i_dmem_rvalid  input  1  load data valid
i_dmem_rdata  input  XLEN  load data
o_wb_valid  output  1  one-cycle writeback strobe
o_wb_rd  output  5  writeback register
o_wb_data  output  XLEN  formatted load result
o_bus_err  output  1  one-cycle watchdog expiry pulse

Behaviour:
- Reset (synchronous, i_rst_n=0 at a clock edge): state IDLE. All outputs 0 except o_ready=1. Watchdog counter cleared. Reset aborts any in-flight transaction with no writeback and no error pulse.
- FSM states: IDLE, REQ, WAIT_R. o_ready = (state==IDLE). o_stall = (state!=IDLE).
- IDLE accept condition: i_valid && opcode in {LOAD 0000011, STORE 0100011} && funct3 legal. Legal loads: 0,1,2,4,5. Legal stores: 0,1,2.
  - Other opcodes or illegal funct3: ignored, no bus activity.
- On accept, register the transaction and go to REQ; o_dmem_req=1 from the next cycle.
  - Address: o_dmem_addr = {addr[31:2],2'b00}.
  - Byte enables: SB/LB/LBU: 0001<<addr[1:0]. SH/LH/LHU: 0011<<{addr[1],0}. SW/LW: 1111.
  - Store data: SB replicates byte 4x. SH replicates half 2x. SW passes through.
- REQ: req, we, be, addr and wdata held stable until i_dmem_gnt=1.
  - On gnt, a store completes: go to IDLE, no writeback.
  - On gnt, a load goes to WAIT_R. req drops the cycle after gnt.
  - i_dmem_rvalid seen while in REQ is ignored.
- WAIT_R: on i_dmem_rvalid, format the data and go to IDLE. The same clock edge registers o_wb_valid=1 for exactly one cycle with o_wb_rd and o_wb_data.
  - o_wb_valid is suppressed when rd==0 (the transaction still completes).
- Load formatting, selected by addr[1:0]:
  - LB: sign-extend the selected byte.
  - LBU: zero-extend the selected byte.
  - LH: sign-extend the half selected by addr[1].
  - LHU: zero-extend the half selected by addr[1].
  - LW: full word.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entering REQ and on entering WAIT_R, and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES: o_bus_err pulses for 1 cycle, req is dropped, state returns to IDLE, no writeback. Late rvalid/gnt arriving in IDLE is ignored.
- Back-to-back: a new accept is possible in the cycle after the return to IDLE. Minimum load latency is accept→wb_valid = 3 cycles (gnt in the first REQ cycle, rvalid in the next).
- Misaligned accesses (without macro): the low address bits outside the access size are ignored (forced alignment).

Optional Feature:
Macro CORE_LSU_MISALIGN_EXC_EN.
- Defined: adds outputs o_misaligned (1) and o_misaligned_addr (XLEN).
  - A legal access with LH/LHU/SH and addr[0]=1, or LW/SW and addr[1:0]!=0, is not issued.
  - Instead, o_misaligned pulses for 1 cycle with the original address. State stays IDLE and there is no writeback.
- Undefined: ports absent; forced-alignment behaviour as above.

Decomposition:
- Package core_lsu_pkg: opcode constants LOAD/STORE; funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW; state enum lsu_state_t {IDLE, REQ, WAIT_R}.
- Sub-module lsu_load_align: combinational rdata/funct3/addr[1:0] → formatted XLEN result.

Test Plan:
- SB, addr 0x1003, wdata 0x000000AB, gnt immediate → be=1000, addr=0x1000, wdata=0xABABABAB, we=1; back in IDLE after 2 cycles; no wb.
- LB at 0x2001 and LBU at 0x2001, rdata 0x00008000, rd=5 → o_wb_data 0xFFFFFF80 and 0x00000080 respectively; wb_valid high exactly one cycle.
- LW, gnt delayed 3 cycles, rvalid 2 cycles after gnt → req/addr stable through the wait; o_stall high throughout; o_ready low; single wb pulse.
- LW, TIMEOUT_CYCLES=4, no rvalid → o_bus_err pulse after 4 WAIT_R cycles; no wb; a following SW issues normally.
- i_rst_n=0 during WAIT_R, then rvalid → IDLE, all outputs 0, no wb.
- With CORE_LSU_MISALIGN_EXC_EN, LW at 0x3002 → o_misaligned=1, o_misaligned_addr=0x3002, no req; same access without the macro → be=1111, addr=0x3000.
